// File: rtl/radix5_input_buffer_if.sv
// Serial-in / frame-out bundle between the sample source, the radix-5 input buffer and the butterfly.
// No state: wires only.
// The slave modport is the buffer's view. The master modport is the view of the source/sink that drives it.
interface radix5_input_buffer_if #(
    parameter int W = 32
);
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_re;
    logic [W-1:0]   in_img;
    logic           out_valid;
    logic           out_ready;
    logic [5*W-1:0] out_re;
    logic [5*W-1:0] out_img;

    modport master (
        output in_valid, in_re, in_img, out_ready,
        input  in_ready, out_valid, out_re, out_img
    );

    modport slave (
        input  in_valid, in_re, in_img, out_ready,
        output in_ready, out_valid, out_re, out_img
    );
endinterface

// File: rtl/radix5_input_buffer.sv
// Collects 5 serial complex samples into a frame. Two banks ping-pong so the next frame fills while the current one is read.
// Latency: the frame is presented in the cycle after its 5th sample is accepted, as long as that bank is the read bank.
// Backpressure: in_ready drops only while both banks are full, and a frame is held stable until out_ready consumes it.
module radix5_input_buffer #(
    parameter int W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    radix5_input_buffer_if.slave  bus
);
    logic           wsel_q, wsel_d;
    logic [2:0]     widx_q, widx_d;
    logic           rsel_q, rsel_d;
    logic [1:0]     full_q, full_d;
    logic [W-1:0]   re_q  [2][5];
    logic [W-1:0]   re_d  [2][5];
    logic [W-1:0]   img_q [2][5];
    logic [W-1:0]   img_d [2][5];

    logic           accept;
    logic           drain;
    logic [5*W-1:0] out_re_w;
    logic [5*W-1:0] out_img_w;

    // An accept needs the write bank to be free. A drain needs the read bank to be full.
    // So one edge can never accept into and drain from the same bank.
    assign accept        = bus.in_valid & ~full_q[wsel_q];
    assign drain         = bus.out_ready & full_q[rsel_q];
    assign bus.in_ready  = ~full_q[wsel_q];
    assign bus.out_valid = full_q[rsel_q];
    assign bus.out_re    = out_re_w;
    assign bus.out_img   = out_img_w;

    // Present the read bank straight from storage, with word k at bits [W*k +: W].
    always_comb begin
        out_re_w  = '0;
        out_img_w = '0;
        for (int k = 0; k < 5; k++) begin
            out_re_w[W*k +: W]  = re_q[rsel_q][k];
            out_img_w[W*k +: W] = img_q[rsel_q][k];
        end
    end

    // Next state: write the accepted sample, close the frame on index 4, and free the bank on a drain.
    always_comb begin
        wsel_d = wsel_q;
        widx_d = widx_q;
        rsel_d = rsel_q;
        full_d = full_q;
        re_d   = re_q;
        img_d  = img_q;
        if (accept) begin
            re_d[wsel_q][widx_q]  = bus.in_re;
            img_d[wsel_q][widx_q] = bus.in_img;
            if (widx_q == 3'd4) begin
                full_d[wsel_q] = 1'b1;
                wsel_d         = ~wsel_q;
                widx_d         = 3'd0;
            end else begin
                widx_d = widx_q + 3'd1;
            end
        end
        if (drain) begin
            full_d[rsel_q] = 1'b0;
            rsel_d         = ~rsel_q;
        end
    end

    // State register. Reset takes effect at once and wipes all frames and the stored data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wsel_q <= 1'b0;
            widx_q <= 3'd0;
            rsel_q <= 1'b0;
            full_q <= 2'b00;
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < 5; k++) begin
                    re_q[b][k]  <= '0;
                    img_q[b][k] <= '0;
                end
            end
        end else begin
            wsel_q <= wsel_d;
            widx_q <= widx_d;
            rsel_q <= rsel_d;
            full_q <= full_d;
            re_q   <= re_d;
            img_q  <= img_d;
        end
    end
endmodule

// File: tb/tb_radix5_input_buffer.sv
// Self-checking bench for radix5_input_buffer.
// The reference model tracks accepted samples as a partial-frame queue plus a queue of complete frames (at most two).
// Inputs are driven just after the falling edge, and outputs are checked at the falling edge.
module tb_radix5_input_buffer;
    localparam int W = 32;
    typedef logic [5*W-1:0] frame_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    radix5_input_buffer_if #(.W(W)) bus ();
    radix5_input_buffer #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Reference model: samples of the frame being filled, and complete frames awaiting drain.
    logic [W-1:0] part_re[$];
    logic [W-1:0] part_img[$];
    frame_t       fr_re[$];
    frame_t       fr_img[$];

    function automatic frame_t ramp(input int base, input int step);
        frame_t f;
        f = '0;
        for (int k = 0; k < 5; k++) f[W*k +: W] = W'(base + step * k);
        return f;
    endfunction

    task automatic model_clear();
        part_re.delete(); part_img.delete(); fr_re.delete(); fr_img.delete();
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, and return at the next falling edge.
    // Two buffered frames means no room. Any buffered frame can be drained.
    task automatic cycle(input logic v, input logic [W-1:0] re, input logic [W-1:0] img, input logic ordy);
        bit acc, drn;
        frame_t fre, fim;
        bus.in_valid = v; bus.in_re = re; bus.in_img = img; bus.out_ready = ordy;
        acc = v && (fr_re.size() < 2);
        drn = ordy && (fr_re.size() > 0);
        @(posedge clk);
        if (drn) begin
            void'(fr_re.pop_front());
            void'(fr_img.pop_front());
        end
        if (acc) begin
            part_re.push_back(re);
            part_img.push_back(img);
            if (part_re.size() == 5) begin
                for (int k = 0; k < 5; k++) begin
                    fre[W*k +: W] = part_re[k];
                    fim[W*k +: W] = part_img[k];
                end
                fr_re.push_back(fre);
                fr_img.push_back(fim);
                part_re.delete();
                part_img.delete();
            end
        end
        @(negedge clk);
    endtask

    // Reset pulse between edges; called at a falling edge so no rising edge intervenes.
    task automatic pulse_reset();
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.in_re = '0; bus.in_img = '0;
        rst = 1'b1;
        #3;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        @(posedge clk); @(negedge clk);
        checks++; if (bus.out_re !== '0) begin failures++; $display("FAIL reset_out_re: got %h expected 0", bus.out_re); end
        checks++; if (bus.out_img !== '0) begin failures++; $display("FAIL reset_out_img: got %h expected 0", bus.out_img); end
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_single_frame();
        for (int k = 1; k <= 5; k++) begin
            cycle(1'b1, W'(k), W'(10 * k), 1'b0);
            checks++;
            if (bus.out_valid !== (k == 5)) begin
                failures++; $display("FAIL single_out_valid[%0d]: got %b expected %b", k, bus.out_valid, k == 5);
            end
        end
        checks++; if (bus.out_re !== ramp(1, 1)) begin failures++; $display("FAIL single_out_re: got %h expected %h", bus.out_re, ramp(1, 1)); end
        checks++; if (bus.out_img !== ramp(10, 10)) begin failures++; $display("FAIL single_out_img: got %h expected %h", bus.out_img, ramp(10, 10)); end
        pulse_reset();
    endtask

    task automatic test_backpressure();
        for (int k = 1; k <= 10; k++) cycle(1'b1, W'(k), W'(100 + k), 1'b0);
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_in_ready: got %b expected 0", bus.in_ready); end
        cycle(1'b1, W'(11), W'(111), 1'b0);
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_ignored_in_ready: got %b expected 0", bus.in_ready); end
        checks++; if (bus.out_re !== ramp(1, 1)) begin failures++; $display("FAIL bp_hold_re: got %h expected %h", bus.out_re, ramp(1, 1)); end
        cycle(1'b0, '0, '0, 1'b1);
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_after_drain_in_ready: got %b expected 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_second_valid: got %b expected 1", bus.out_valid); end
        checks++; if (bus.out_re !== ramp(6, 1)) begin failures++; $display("FAIL bp_second_re: got %h expected %h", bus.out_re, ramp(6, 1)); end
        checks++; if (bus.out_img !== ramp(106, 1)) begin failures++; $display("FAIL bp_second_img: got %h expected %h", bus.out_img, ramp(106, 1)); end
        pulse_reset();
    endtask

    task automatic test_back_to_back();
        int nfr = 0;
        int drops = 0;
        for (int i = 0; i < 55; i++) begin
            if (bus.out_valid === 1'b1) begin
                checks++;
                if (bus.out_re !== ramp(5 * nfr, 1)) begin
                    failures++; $display("FAIL stream_frame[%0d]: got %h expected %h", nfr, bus.out_re, ramp(5 * nfr, 1));
                end
                nfr++;
            end
            if (i < 50 && bus.in_ready !== 1'b1) drops++;
            if (i < 50) cycle(1'b1, W'(i), W'(1000 + i), 1'b1);
            else        cycle(1'b0, '0, '0, 1'b1);
        end
        checks++; if (drops !== 0) begin failures++; $display("FAIL stream_in_ready_drops: got %0d expected 0", drops); end
        checks++; if (nfr !== 10) begin failures++; $display("FAIL stream_frame_count: got %0d expected 10", nfr); end
        pulse_reset();
    endtask

    task automatic test_gapped_reset();
        for (int k = 0; k < 5; k++) cycle(k % 2 == 0, W'(k / 2 + 1), W'(7), 1'b0);
        pulse_reset();
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, W'(100 + k), W'(200 + k), 1'b0);
            checks++;
            if (bus.out_valid !== (k == 4)) begin
                failures++; $display("FAIL gapped_out_valid[%0d]: got %b expected %b", k, bus.out_valid, k == 4);
            end
        end
        checks++; if (bus.out_re !== ramp(100, 1)) begin failures++; $display("FAIL gapped_out_re: got %h expected %h", bus.out_re, ramp(100, 1)); end
        checks++; if (bus.out_img !== ramp(200, 1)) begin failures++; $display("FAIL gapped_out_img: got %h expected %h", bus.out_img, ramp(200, 1)); end
        pulse_reset();
    endtask

    task automatic test_hold_stability();
        int bad = 0;
        for (int k = 0; k < 5; k++) cycle(1'b1, W'(40 + k), W'(60 + k), 1'b0);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, W'($urandom), W'($urandom), 1'b0);
            if (bus.out_re !== ramp(40, 1) || bus.out_img !== ramp(60, 1) || bus.out_valid !== 1'b1) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL hold_stable_cycles: got %0d unstable expected 0", bad); end
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL hold_in_ready: got %b expected 0", bus.in_ready); end
        pulse_reset();
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 5; k++) cycle(1'b1, W'(k + 9), W'(k + 19), 1'b0);
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL async_pre_valid: got %b expected 1", bus.out_valid); end
        bus.in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL async_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL async_in_ready: got %b expected 1", bus.in_ready); end
        checks++; if (bus.out_re !== '0) begin failures++; $display("FAIL async_out_re: got %h expected 0", bus.out_re); end
        rst = 1'b0;
        model_clear();
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            checks++;
            if (bus.in_ready !== (fr_re.size() < 2)) begin
                failures++; $display("FAIL rand_in_ready[%0d]: got %b expected %b", i, bus.in_ready, fr_re.size() < 2);
            end
            checks++;
            if (bus.out_valid !== (fr_re.size() > 0)) begin
                failures++; $display("FAIL rand_out_valid[%0d]: got %b expected %b", i, bus.out_valid, fr_re.size() > 0);
            end
            if (fr_re.size() > 0) begin
                checks++;
                if (bus.out_re !== fr_re[0] || bus.out_img !== fr_img[0]) begin
                    failures++; $display("FAIL rand_frame[%0d]: got %h/%h expected %h/%h", i, bus.out_re, bus.out_img, fr_re[0], fr_img[0]);
                end
            end
            cycle($urandom_range(0, 3) != 0, W'($urandom), W'($urandom), $urandom_range(0, 2) == 0);
        end
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_single_frame();
        test_backpressure();
        test_back_to_back();
        test_gapped_reset();
        test_hold_stability();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/radix5_input_buffer.md
RADIX5_INPUT_BUFFER -- requirements
Module: radix5_input_buffer

Interface
REQ-001 Parameter W, default 32, SHALL set the width of each real/imaginary word (IEEE-754 single-precision bit pattern, passed through unmodified).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 in_valid  input  1  SHALL indicate that in_re/in_img carry a sample.
REQ-005 in_ready  output  1  SHALL indicate that the block can accept a sample this cycle.
REQ-006 in_re, in_img  input  W each  SHALL carry the serial complex sample.
REQ-007 out_valid  output  1  SHALL indicate that a complete 5-point frame is presented.
REQ-008 out_ready  input  1  SHALL indicate that the downstream radix-5 butterfly consumes the frame this cycle.
REQ-009 out_re, out_img  output  5*W each  SHALL carry sample k of the frame at bits [W*k+W-1 : W*k], k=0..4, with k=0 the first sample accepted.

Function
REQ-010 Storage SHALL be two banks (A, B), each holding 5 complex words plus a full flag.
REQ-011 State SHALL comprise: write-bank select wsel, write index widx (0..4), read-bank select rsel, full[A], full[B].
REQ-012 in_ready SHALL equal NOT full[wsel], combinationally.
REQ-013 An accept (in_valid AND in_ready at a clock edge) SHALL write the sample to bank[wsel][widx] and increment widx.
REQ-014 An accept with widx==4 SHALL set full[wsel], toggle wsel and return widx to 0.
REQ-015 in_valid while in_ready==0 SHALL be ignored: no write, no index change.
REQ-016 out_valid SHALL equal full[rsel]; out_re/out_img SHALL drive bank[rsel] directly from registers.
REQ-017 A drain (out_valid AND out_ready at a clock edge) SHALL clear full[rsel] and toggle rsel.
REQ-018 Frame output data SHALL stay stable while out_valid==1 and out_ready==0.
REQ-019 out_ready while out_valid==0 SHALL have no effect.
REQ-020 Latency: the 5th sample accepted at edge n SHALL give out_valid==1 after edge n (first visible in the following cycle), provided that bank is rsel.
REQ-021 An accept and a drain in the same cycle SHALL both take effect (different banks), sustaining 1 sample/cycle with out_ready held high.
REQ-022 With both banks full, in_ready SHALL be 0 until a drain; in_ready SHALL rise in the cycle after the draining edge.
REQ-023 No arithmetic SHALL be performed on the data; frame order SHALL equal arrival order, with no frame dropped or duplicated.

Reset
REQ-024 On rst==1 the block SHALL immediately set wsel=rsel=0, widx=0, full[A]=full[B]=0, and all storage words to 0, without waiting for clk.
REQ-025 During and after reset: in_ready=1, out_valid=0, out_re=out_img=0.
REQ-026 Reset asserted mid-frame or with full banks SHALL discard all partial and complete frames; the first accept after release SHALL become sample 0 of a new frame.

Verification
REQ-027 Single frame: after reset, send re=1..5, img=10..50 on consecutive cycles with out_ready=0 -> out_valid=1 in the cycle after the 5th accept; out_re words k=0..4 = 1,2,3,4,5; out_img = 10..50.
REQ-028 Backpressure: send 10 samples (re=1..10) with out_ready=0 -> in_ready=0 after the 10th accept; an 11th sample held on in_valid is ignored; pulse out_ready for one cycle -> frame 1..5 drained, out shows 6..10, in_ready=1 the next cycle.
REQ-029 Streaming: 50 back-to-back samples re=0..49 with out_ready=1 throughout -> in_ready never drops; 10 frames emitted in order, frame j holds 5j..5j+4.
REQ-030 Gapped input: in_valid toggling every other cycle across 3 samples, then reset pulse, then re=100..104 -> output frame is 100..104; out_valid stays 0 before the 5th post-reset accept.
REQ-031 Hold stability: a full frame held with out_ready=0 for 20 cycles while in_valid=1 fills the other bank -> out_re/out_img bits unchanged for all 20 cycles.
REQ-032 Async reset: assert rst between clock edges while out_valid=1 -> out_valid=0 and in_ready=1 before the next rising edge of clk.
